// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming codeword path (deserializer, hamFix, benches).
package ham_pkg;
    localparam int HAM_WIDTH  = 15;
    localparam int DATA_WIDTH = 11;

    typedef logic [15:1] codeword_t;

    typedef enum logic {IDLE, SHIFT} deser_state_t;
endpackage

// File: rtl/ham_out_reg.sv
// One-entry valid/ready holding register. A load always wins; loading over an
// unconsumed word that is not being taken this cycle latches a sticky overrun.
module ham_out_reg #(
    parameter int W = 15
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);
    logic [W-1:0] data_d, data_q;
    logic         valid_d, valid_q;
    logic         ovr_d, ovr_q;

    // Next-state: load has priority over consume; data moves only on load.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            if (valid_q && !ready) ovr_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;
endmodule

// File: rtl/ham_deserializer.sv
// Assembles an LSB-first framed serial stream into a Hamming codeword and
// hands it to a one-entry valid/ready output register. Early sof and long
// mid-frame stalls abort the frame with a one-cycle frame_err pulse.
module ham_deserializer
    import ham_pkg::*;
#(
    parameter int HAM_WIDTH    = ham_pkg::HAM_WIDTH,
    parameter int IDLE_TIMEOUT = 31
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              sof,
    output logic [HAM_WIDTH:1] ham,
    output logic              ham_valid,
    input  logic              ham_ready,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CNT_W   = $clog2(HAM_WIDTH + 1);
    localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);

    deser_state_t        state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [CNT_W-1:0]    nxt_idx;
    logic [STALL_W-1:0]  stall_d, stall_q;
    logic [HAM_WIDTH:1]  sr_d, sr_q;
    logic                err_d, err_q;
    logic                load;

    // Frame FSM: positional bit writes, abort on early sof or stall timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        sr_d    = sr_q;
        err_d   = 1'b0;
        load    = 1'b0;
        nxt_idx = cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (bit_valid && sof) begin
                    sr_d[1] = bit_in;
                    cnt_d   = CNT_W'(1);
                    stall_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    stall_d = '0;
                    if (sof) begin
                        // Restart on the new frame's first bit.
                        err_d   = 1'b1;
                        sr_d[1] = bit_in;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        sr_d[nxt_idx] = bit_in;
                        cnt_d         = nxt_idx;
                        if (nxt_idx == CNT_W'(HAM_WIDTH)) begin
                            // sr_d already holds the finished word.
                            load    = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end else if (stall_q == STALL_W'(IDLE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    stall_d = '0;
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers; reset discards any partial frame silently.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
            sr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
        end
    end

    assign frame_err = err_q;

    ham_out_reg #(.W(HAM_WIDTH)) u_out (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (sr_d),
        .ready     (ham_ready),
        .data      (ham),
        .valid     (ham_valid),
        .overrun   (overrun)
    );
endmodule

// File: tb/tb_ham_deserializer.sv
// Bench for ham_deserializer: table of whole frames, hand-written abort /
// timeout / overrun / reset sequences, and randomized framed traffic checked
// every cycle against a frame-level model of the output register.
module tb_ham_deserializer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        sof = 1'b0;
    logic        ham_ready = 1'b0;
    logic [15:1] ham;
    logic        ham_valid;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    // Frame-level model: held word, pending flag, sticky overrun.
    logic [14:0] m_ham  = '0;
    logic        m_pend = 1'b0;
    logic        m_ovr  = 1'b0;
    int          rdy_mode = 0;  // 0 always ready, 1 never ready, 2 random

    typedef struct {
        logic [14:0] word;
        int          gmax;
        int          rdy;
        logic [14:0] exp_ham;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[5];

    ham_deserializer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .sof       (sof),
        .ham       (ham),
        .ham_valid (ham_valid),
        .ham_ready (ham_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; the model advances and all outputs are checked.
    task automatic step(input logic v, input logic b, input logic s,
                        input logic ld, input logic [14:0] w, input logic err);
        logic r;
        r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        bit_valid = v; bit_in = b; sof = s; ham_ready = r;
        @(posedge clock); #1;
        if (ld) begin
            if (m_pend && !r) m_ovr = 1'b1;
            m_pend = 1'b1;
            m_ham  = w;
        end else if (m_pend && r) begin
            m_pend = 1'b0;
        end
        chk("frame_err", 32'(frame_err), 32'(err));
        chk("ham_valid", 32'(ham_valid), 32'(m_pend));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("ham",       32'(ham),       32'(m_ham));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    endtask

    // Sends bits [0..n-1] of w LSB-first with sof on bit 0 and random gaps up to gmax.
    task automatic send_frame(input logic [14:0] w, input int n, input int gmax, input logic err0);
        for (int i = 0; i < n; i++) begin
            if (gmax > 0) idle($urandom_range(0, gmax));
            step(1'b1, w[i], (i == 0), (i == 14), w, (i == 0) ? err0 : 1'b0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; bit_valid = 1'b1; sof = 1'b1; bit_in = 1'b1; ham_ready = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        m_ham = '0; m_pend = 1'b0; m_ovr = 1'b0;
        chk("rst_ham",       32'(ham),       0);
        chk("rst_ham_valid", 32'(ham_valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun",   32'(overrun),   0);
    endtask

    initial begin
        vecs[0] = '{15'h0007, 0,  0, 15'h0007, 1'b0};
        vecs[1] = '{15'h7FFF, 5,  0, 15'h7FFF, 1'b0};
        vecs[2] = '{15'h5555, 30, 0, 15'h5555, 1'b0};
        vecs[3] = '{15'h2AAA, 2,  1, 15'h2AAA, 1'b0};
        vecs[4] = '{15'h4001, 0,  1, 15'h4001, 1'b1};

        idle(2);
        do_reset();

        // Table: whole frames, checked right after the completing edge.
        for (int t = 0; t < 5; t++) begin
            rdy_mode = vecs[t].rdy;
            send_frame(vecs[t].word, 15, vecs[t].gmax, 1'b0);
            chk("tbl_ham",     32'(ham),       32'(vecs[t].exp_ham));
            chk("tbl_valid",   32'(ham_valid), 1);
            chk("tbl_overrun", 32'(overrun),   32'(vecs[t].exp_ovr));
            idle(1);
        end

        // Overrun: two frames back-to-back with no consumer; sticky until reset.
        do_reset();
        rdy_mode = 1;
        send_frame(15'h0007, 15, 0, 1'b0);
        chk("ovr_first_ham", 32'(ham), 32'h0007);
        chk("ovr_first_flag", 32'(overrun), 0);
        send_frame(15'h7FF8, 15, 0, 1'b0);
        chk("ovr_second_ham", 32'(ham), 32'h7FF8);
        chk("ovr_flag", 32'(overrun), 1);
        rdy_mode = 0;
        idle(4);
        chk("ovr_sticky", 32'(overrun), 1);
        do_reset();

        // Early sof after 6 bits aborts; the restarted frame completes cleanly.
        send_frame(15'h1234, 6, 0, 1'b0);
        send_frame(15'h7FFF, 15, 0, 1'b1);
        chk("abort_ham", 32'(ham), 32'h7FFF);
        idle(2);

        // Stall timeout after 9 bits, then sof-less bits are ignored in IDLE.
        send_frame(15'h3C3C, 9, 0, 1'b0);
        idle(30);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("timeout_no_valid", 32'(ham_valid), 0);

        // Reset at bit 10 of a frame, then a fresh frame.
        send_frame(15'h6F0F, 9, 0, 1'b0);
        do_reset();
        send_frame(15'h5555, 15, 0, 1'b0);
        chk("post_rst_ham", 32'(ham), 32'h5555);
        idle(2);

        // Randomized framed traffic with random gaps and a random consumer.
        rdy_mode = 2;
        for (int f = 0; f < 60; f++)
            send_frame(15'($urandom), 15, ($urandom_range(0, 3) == 0) ? 30 : 3, 1'b0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
